memory_arbiter: RTL and testbench

Shares the single-port, 8192-word RAM between the instruction-fetch requester and the load/store data requester of the control unit. It serialises requests, drives the RAM address, write-data and read/write lines, and returns read data with a one-cycle acknowledge pulse. It sits between `control_unit` and `random_access_memory`, replacing the direct `ram_a`/`ram_din`/`ram_rw` drive.

---
 rtl/memory_arbiter.sv | 146 ++++++++++++++
 tb/tb_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single-port RAM between fetch (if_*) and data (d_*) requesters.
// Ports: clk, rst_n, if_req/if_addr/if_ack/if_rdata/if_err,
//        d_req/d_we/d_addr/d_wdata/d_ack/d_rdata/d_err, ram_a/ram_din/ram_rw/ram_dout.
// Option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data-first fixed).
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_rw,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    state_t state, state_nxt;

    logic if_elig, d_elig;
    logic pick_d;
    logic grant, grant_d, grant_oor;
    logic owner_d, owner_we;

    // A port is masked in its own ack cycle so a held req is a new request.
    assign if_elig = if_req & ~if_ack;
    assign d_elig  = d_req & ~d_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_d;

    assign pick_d = ptr_d;

    // Points at the port that wins the next tie: the one not granted last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_d <= 1'b1;
        end else if (grant) begin
            ptr_d <= ~grant_d;
        end
    end
`else
    assign pick_d = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        grant_oor = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_elig || d_elig) begin
                    grant     = 1'b1;
                    grant_d   = d_elig && (!if_elig || pick_d);
                    grant_oor = grant_d ? (d_addr >= DEPTH)
                                        : (if_addr >= DEPTH);
                    state_nxt = grant_oor ? DONE : ISSUE;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_a    <= '0;
            ram_din  <= '0;
            ram_rw   <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_err   <= 1'b0;
            d_err    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            owner_d  <= 1'b0;
            owner_we <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if_err <= 1'b0;
            d_err  <= 1'b0;
            // Write enable is only ever high for the single ISSUE cycle.
            ram_rw <= 1'b0;
            if (grant) begin
                owner_d  <= grant_d;
                owner_we <= grant_d & d_we;
                if (!grant_oor) begin
                    ram_a  <= grant_d ? d_addr : if_addr;
                    ram_rw <= grant_d & d_we;
                    if (grant_d) begin
                        ram_din <= d_wdata;
                    end
                end
            end
            if (state == RESP) begin
                if (owner_d) begin
                    d_ack <= 1'b1;
                    if (!owner_we) begin
                        d_rdata <= ram_dout;
                    end
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= ram_dout;
                end
            end
            if (state == DONE) begin
                if (owner_d) begin
                    d_ack <= 1'b1;
                    d_err <= 1'b1;
                end else begin
                    if_ack <= 1'b1;
                    if_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized and directed bench for memory_arbiter.
// Transaction-level reference memory plus arbitration-rule predictions.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 8192;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din;
    logic          ram_rw;
    logic [DW-1:0] ram_dout;

    memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_ack  (if_ack),
        .if_rdata(if_rdata),
        .if_err  (if_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .ram_a   (ram_a),
        .ram_din (ram_din),
        .ram_rw  (ram_rw),
        .ram_dout(ram_dout)
    );

    // Registered single-port RAM standing in for random_access_memory.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_rw) mem[ram_a[12:0]] <= ram_din;
        ram_dout <= mem[ram_a[12:0]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_d_rd;
    logic [DW-1:0] exp_if_rd;
    bit            last_d;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner when both ports are eligible; otherwise the only eligible one.
    function automatic bit pick(input bit d_el, input bit f_el);
`ifdef ARB_ROUND_ROBIN_EN
        if (d_el && f_el) return !last_d;
`else
        if (d_el && f_el) return 1'b1;
`endif
        return d_el;
    endfunction

    // One transaction on one port. exact: port runs alone, latency is fixed.
    task automatic txn(input bit is_d, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit exact);
        bit oor;
        bit got;
        int lat;
        int rw_cnt;
        oor = (addr >= AW'(DEPTH));
        got = 1'b0;
        lat = 0;
        rw_cnt = 0;
        if (is_d) begin
            d_we = we;
            d_addr = addr;
            d_wdata = wdata;
            d_req = 1'b1;
        end else begin
            if_addr = addr;
            if_req = 1'b1;
        end
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (ram_rw) rw_cnt++;
            if (exact && lat == 1 && !oor) check("ram_a", ram_a, addr);
            got = is_d ? d_ack : if_ack;
        end
        check("ack_seen", got, 1);
        if (exact) begin
            check("latency", lat, oor ? 2 : 3);
            check("rw_pulses", rw_cnt, (is_d && we && !oor) ? 1 : 0);
        end else begin
            check("lat_bound", lat <= 6, 1);
        end
        if (is_d) begin
            if (!oor && !we) exp_d_rd = ref_mem[addr[12:0]];
            check("d_err", d_err, oor);
            check("d_rdata", d_rdata, exp_d_rd);
            if (!oor && we) ref_mem[addr[12:0]] = wdata;
            d_req = 1'b0;
        end else begin
            if (!oor) exp_if_rd = ref_mem[addr[12:0]];
            check("if_err", if_err, oor);
            check("if_rdata", if_rdata, exp_if_rd);
            if_req = 1'b0;
        end
        last_d = is_d;
        tick();
        check("ack_pulse", is_d ? d_ack : if_ack, 0);
        if (exact) check("rw_idle", ram_rw, 0);
    endtask

    // Both ports raise reads together and hold them for n grants.
    task automatic contend(input int n);
        bit exp_d;
        int seen;
        int t;
        int last_t;
        logic [AW-1:0] fa;
        logic [AW-1:0] da;
        seen = 0;
        t = 0;
        last_t = 0;
        fa = AW'($urandom_range(0, 63));
        da = AW'($urandom_range(0, 63));
        if_addr = fa;
        d_addr = da;
        d_we = 1'b0;
        if_req = 1'b1;
        d_req = 1'b1;
        exp_d = pick(1'b1, 1'b1);
        while (seen < n && t < 60) begin
            tick();
            t++;
            if (d_ack || if_ack) begin
                check("cont_order", d_ack, exp_d);
                check("cont_gap", t - last_t, 3);
                if (d_ack) begin
                    exp_d_rd = ref_mem[da[12:0]];
                    check("cont_d_rdata", d_rdata, exp_d_rd);
                end else begin
                    exp_if_rd = ref_mem[fa[12:0]];
                    check("cont_if_rdata", if_rdata, exp_if_rd);
                end
                seen++;
                last_t = t;
                last_d = d_ack;
                // The acking port is masked, so only the other is eligible.
                exp_d = pick(!d_ack, d_ack);
                if (seen == n) begin
                    if_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        check("cont_done", seen, n);
        tick();
    endtask

    task automatic held_fetch();
        int n;
        if_addr = 32'd7;
        if_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!if_ack && n < 20);
        check("held_first_lat", n, 3);
        check("held_first_data", if_rdata, ref_mem[7]);
        n = 0;
        do begin tick(); n++; end while (!if_ack && n < 20);
        check("held_gap", n, 4);
        check("held_second_data", if_rdata, ref_mem[7]);
        exp_if_rd = ref_mem[7];
        last_d = 1'b0;
        if_req = 1'b0;
        tick();
    endtask

    task automatic port_worker(input bit is_d, input int count);
        logic [AW-1:0] a;
        bit we;
        for (int i = 0; i < count; i++) begin
            a = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) a = AW'(DEPTH) + AW'($urandom_range(0, 3));
            we = is_d && ($urandom_range(0, 1) == 1);
            txn(is_d, we, a, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        last_d = 1'b0;
        exp_d_rd = '0;
        exp_if_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        rst_n = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        repeat (3) tick();
        check("rst_ram_a", ram_a, 0);
        check("rst_ram_rw", ram_rw, 0);
        check("rst_acks", {if_ack, d_ack, if_err, d_err}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        rst_n = 1'b1;
        tick();

        txn(1'b0, 1'b0, 32'd5, '0, 1'b1);
        txn(1'b1, 1'b1, 32'd10, 32'h12345678, 1'b1);
        txn(1'b1, 1'b0, 32'd10, '0, 1'b1);
        check("wr_rd_value", d_rdata, 32'h12345678);
        txn(1'b1, 1'b0, 32'd8192, '0, 1'b1);
        txn(1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 1'b1);
        txn(1'b0, 1'b0, 32'd8191, '0, 1'b1);
        txn(1'b0, 1'b0, 32'd9000, '0, 1'b1);

        held_fetch();
        contend(4);
        // Data granted last: tie now separates round robin from fixed priority.
        txn(1'b1, 1'b0, 32'd2, '0, 1'b1);
        contend(2);

        fork
            port_worker(1'b1, 40);
            port_worker(1'b0, 40);
        join
        tick();

        d_we = 1'b1;
        d_addr = 32'd3;
        d_wdata = ~ref_mem[3];
        d_req = 1'b1;
        tick();
        check("mid_issue_rw", ram_rw, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rw", ram_rw, 0);
        check("mid_rst_ram", {ram_a, ram_din}, 0);
        check("mid_rst_acks", {if_ack, d_ack, if_err, d_err}, 0);
        check("mid_rst_rdata", {if_rdata, d_rdata}, 0);
        d_req = 1'b0;
        exp_d_rd = '0;
        exp_if_rd = '0;
        last_d = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_ack", d_ack, 0);
        end
        check("mid_mem3", mem[3], ref_mem[3]);
        txn(1'b1, 1'b0, 32'd3, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
